// File: rtl/pic_cmd_writer.sv
// 8259A write-port bus master: init sequence ICW1..ICW4/OCW1 on start,
// then single OCW writes through a req/ack handshake.
module pic_cmd_writer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1_init,
    input  logic       ocw_req,
    input  logic [1:0] ocw_sel,
    input  logic [7:0] ocw_data,
    output logic       ocw_ack,
    output logic       ocw_err,
    output logic       busy,
    output logic       done,
    output logic       CS,
    output logic       write,
    output logic       Read,
    output logic       A0,
    output logic [7:0] dataBuffer,
    output logic       dataBuffer_oe
);

    localparam int CW = 8;
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] RECOV_LAST = CW'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1I, S_OCWX
    } seq_t;

    typedef enum logic [1:0] {
        P_SETUP, P_PULSE, P_HOLD, P_RECOV
    } phase_t;

    seq_t          seq;
    seq_t          nxt_seq;
    phase_t        phase;
    logic [CW-1:0] cnt;
    logic [7:0]    icw1_q;
    logic [7:0]    icw2_q;
    logic [7:0]    icw3_q;
    logic [7:0]    icw4_q;
    logic [7:0]    ocw1_q;
    logic [8:0]    nxt_byte;
    logic [7:0]    ocw_enc;

    assign Read = 1'b1;

    // OCW2 forces D4:D3=00, OCW3 forces 01; OCW1 passes through
    assign ocw_enc = (ocw_sel == 2'b01) ? ocw_data
                   : {ocw_data[7:5], 1'b0, ocw_sel[0], ocw_data[2:0]};

    always_comb begin
        nxt_seq = S_IDLE;
        unique case (seq)
            S_ICW1:  nxt_seq = S_ICW2;
            S_ICW2:  nxt_seq = !icw1_q[1] ? S_ICW3
                             : (icw1_q[0] ? S_ICW4 : S_OCW1I);
            S_ICW3:  nxt_seq = icw1_q[0] ? S_ICW4 : S_OCW1I;
            S_ICW4:  nxt_seq = S_OCW1I;
            default: nxt_seq = S_IDLE;
        endcase
        nxt_byte = {1'b1, ocw1_q};
        unique case (nxt_seq)
            S_ICW2:  nxt_byte = {1'b1, icw2_q};
            S_ICW3:  nxt_byte = {1'b1, icw3_q};
            S_ICW4:  nxt_byte = {1'b1, icw4_q};
            default: nxt_byte = {1'b1, ocw1_q};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq           <= S_IDLE;
            phase         <= P_SETUP;
            cnt           <= '0;
            icw1_q        <= '0;
            icw2_q        <= '0;
            icw3_q        <= '0;
            icw4_q        <= '0;
            ocw1_q        <= '0;
            ocw_ack       <= 1'b0;
            ocw_err       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            CS            <= 1'b1;
            write         <= 1'b1;
            A0            <= 1'b0;
            dataBuffer    <= '0;
            dataBuffer_oe <= 1'b0;
        end else begin
            ocw_ack <= 1'b0;
            ocw_err <= 1'b0;
            if (seq == S_IDLE) begin
                if (start) begin
                    icw1_q        <= icw1;
                    icw2_q        <= icw2;
                    icw3_q        <= icw3;
                    icw4_q        <= icw4;
                    ocw1_q        <= ocw1_init;
                    done          <= 1'b0;
                    seq           <= S_ICW1;
                    phase         <= P_SETUP;
                    cnt           <= '0;
                    busy          <= 1'b1;
                    CS            <= 1'b0;
                    dataBuffer_oe <= 1'b1;
                    write         <= 1'b1;
                    A0            <= 1'b0;
                    dataBuffer    <= icw1 | 8'h10;
                end else if (ocw_req && done) begin
                    if (ocw_sel == 2'b00) begin
                        ocw_err <= 1'b1;
                    end else begin
                        seq           <= S_OCWX;
                        phase         <= P_SETUP;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        CS            <= 1'b0;
                        dataBuffer_oe <= 1'b1;
                        write         <= 1'b1;
                        A0            <= (ocw_sel == 2'b01);
                        dataBuffer    <= ocw_enc;
                    end
                end
            end else begin
                unique case (phase)
                    P_SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            phase <= P_PULSE;
                            cnt   <= '0;
                            write <= 1'b0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    P_PULSE: begin
                        if (cnt == PULSE_LAST) begin
                            phase <= P_HOLD;
                            write <= 1'b1;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    P_HOLD: begin
                        phase         <= P_RECOV;
                        cnt           <= '0;
                        CS            <= 1'b1;
                        dataBuffer_oe <= 1'b0;
                        if (seq == S_OCWX && RECOV_LAST == '0)
                            ocw_ack <= 1'b1;
                    end
                    P_RECOV: begin
                        if (cnt == RECOV_LAST) begin
                            if (nxt_seq == S_IDLE) begin
                                seq  <= S_IDLE;
                                busy <= 1'b0;
                                if (seq == S_OCW1I)
                                    done <= 1'b1;
                            end else begin
                                seq           <= nxt_seq;
                                phase         <= P_SETUP;
                                cnt           <= '0;
                                CS            <= 1'b0;
                                dataBuffer_oe <= 1'b1;
                                A0            <= nxt_byte[8];
                                dataBuffer    <= nxt_byte[7:0];
                            end
                        end else begin
                            cnt <= cnt + ONE;
                            // ack lands on the last recovery cycle
                            if (seq == S_OCWX && (cnt + ONE) == RECOV_LAST)
                                ocw_ack <= 1'b1;
                        end
                    end
                    default: phase <= P_SETUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pic_cmd_writer.sv
// Bench for pic_cmd_writer: bus bytes checked by a scoreboard monitor,
// latencies and handshakes checked by the directed stimulus.
module tb_pic_cmd_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw1_init = '0;
    logic       ocw_req = 1'b0;
    logic [1:0] ocw_sel = '0;
    logic [7:0] ocw_data = '0;
    logic       ocw_ack, ocw_err, busy, done, CS, write, Read, A0, dataBuffer_oe;
    logic [7:0] dataBuffer;

    logic       start2 = 1'b0;
    logic       ocw_ack2, ocw_err2, busy2, done2, CS2, write2, Read2, A02, oe2;
    logic [7:0] data2;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    logic [8:0] exp_q[$];

    pic_cmd_writer dut (
        .clk(clk), .reset(reset), .start(start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw1_init(ocw1_init), .ocw_req(ocw_req), .ocw_sel(ocw_sel),
        .ocw_data(ocw_data), .ocw_ack(ocw_ack), .ocw_err(ocw_err),
        .busy(busy), .done(done), .CS(CS), .write(write), .Read(Read),
        .A0(A0), .dataBuffer(dataBuffer), .dataBuffer_oe(dataBuffer_oe)
    );

    pic_cmd_writer #(.SETUP_CYC(2), .PULSE_CYC(3), .RECOV_CYC(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .icw1(8'h12), .icw2(8'h40), .icw3(8'h00), .icw4(8'h00),
        .ocw1_init(8'hF0), .ocw_req(1'b0), .ocw_sel(2'b00),
        .ocw_data(8'h00), .ocw_ack(ocw_ack2), .ocw_err(ocw_err2),
        .busy(busy2), .done(done2), .CS(CS2), .write(write2), .Read(Read2),
        .A0(A02), .dataBuffer(data2), .dataBuffer_oe(oe2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected (A0,data) per completed write pulse
    int         low_cnt = 0;
    logic       in_byte = 1'b0;
    logic [8:0] cap = '0;
    always @(negedge clk) begin
        if (reset) begin
            low_cnt = 0;
            in_byte = 1'b0;
        end else begin
            if (!CS) begin
                chk("oe_with_cs", int'(dataBuffer_oe), 1);
                if (!in_byte) begin
                    in_byte = 1'b1;
                    cap = {A0, dataBuffer};
                end else begin
                    chk("bus_stable", int'({A0, dataBuffer}), int'(cap));
                end
            end else begin
                in_byte = 1'b0;
            end
            if (!write) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                chk("pulse_width", low_cnt, 2);
                chk("cs_in_hold", int'(CS), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none",
                             {A0, dataBuffer});
                end else begin
                    chk("bus_byte", int'({A0, dataBuffer}),
                        int'(exp_q.pop_front()));
                end
                low_cnt = 0;
            end
            if (ocw_ack) ack_cnt++;
            if (ocw_err) err_cnt++;
        end
    end

    task automatic run_init(input logic [7:0] a, b, c, d, e, input int lat);
        int t0;
        icw1 = a; icw2 = b; icw3 = c; icw4 = d; ocw1_init = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("busy_k1", int'(busy), 1);
        chk("cs_k1", int'(CS), 0);
        for (int i = 0; i < 100 && !done; i++) tick();
        chk("done_latency", cyc - t0, lat);
        chk("busy_after_done", int'(busy), 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_ocw(input logic [1:0] sel, input logic [7:0] d,
                          input logic [8:0] e);
        int t0, a0;
        exp_q.push_back(e);
        a0 = ack_cnt;
        ocw_sel = sel; ocw_data = d; ocw_req = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 20 && !ocw_ack; i++) tick();
        chk("ack_latency", cyc - t0, 5);
        tick();
        ocw_req = 1'b0;
        repeat (8) tick();
        chk("ack_once", ack_cnt - a0, 1);
        chk("ocw_drained", exp_q.size(), 0);
        chk("ocw_idle", int'(busy), 0);
    endtask

    initial begin
        int t0, a0, lowrun, hirun, nlow;
        repeat (3) tick();
        chk("rst_cs", int'(CS), 1);
        chk("rst_write", int'(write), 1);
        chk("rst_oe", int'(dataBuffer_oe), 0);
        reset = 1'b0;
        tick();
        chk("rst_read", int'(Read), 1);
        chk("rst_a0_data", int'({A0, dataBuffer}), 0);
        chk("rst_busy_done", int'({busy, done}), 0);
        chk("rst_ack_err", int'({ocw_ack, ocw_err}), 0);

        // cascade + ICW4: five bytes
        exp_q.push_back(9'h011); exp_q.push_back(9'h117);
        exp_q.push_back(9'h155); exp_q.push_back(9'h18F);
        exp_q.push_back(9'h1FF);
        run_init(8'h11, 8'h17, 8'h55, 8'h8F, 8'hFF, 30);

        do_ocw(2'b10, 8'h3F, 9'h027);
        do_ocw(2'b11, 8'h00, 9'h008);
        do_ocw(2'b01, 8'h5A, 9'h15A);

        // illegal select: error pulse, bus untouched
        a0 = err_cnt;
        ocw_sel = 2'b00; ocw_data = 8'hAA; ocw_req = 1'b1;
        tick();
        chk("err_pulse", int'(ocw_err), 1);
        chk("err_cs", int'(CS), 1);
        ocw_req = 1'b0;
        repeat (6) tick();
        chk("err_once", err_cnt - a0, 1);
        chk("err_no_bus", int'({CS, busy}), 2);

        // single, no ICW4: three bytes
        exp_q.push_back(9'h012); exp_q.push_back(9'h1AB);
        exp_q.push_back(9'h1F0);
        run_init(8'h12, 8'hAB, 8'h00, 8'h00, 8'hF0, 18);

        // D4 forced high on ICW1
        exp_q.push_back(9'h011); exp_q.push_back(9'h120);
        exp_q.push_back(9'h133); exp_q.push_back(9'h144);
        exp_q.push_back(9'h1C3);
        run_init(8'h01, 8'h20, 8'h33, 8'h44, 8'hC3, 30);

        // start and ocw_req together: init first, then the OCW
        a0 = ack_cnt;
        exp_q.push_back(9'h011); exp_q.push_back(9'h117);
        exp_q.push_back(9'h155); exp_q.push_back(9'h18F);
        exp_q.push_back(9'h1FF); exp_q.push_back(9'h1A5);
        icw1 = 8'h11; icw2 = 8'h17; icw3 = 8'h55; icw4 = 8'h8F;
        ocw1_init = 8'hFF;
        ocw_sel = 2'b01; ocw_data = 8'hA5; ocw_req = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("start_wins_done", int'(done), 0);
        for (int i = 0; i < 100 && !done; i++) tick();
        chk("arb_done_lat", cyc - t0, 30);
        tick();
        chk("ocw_after_done", int'({busy, CS}), 2);
        for (int i = 0; i < 20 && !ocw_ack; i++) tick();
        chk("arb_ack", int'(ocw_ack), 1);
        tick();
        ocw_req = 1'b0;
        repeat (8) tick();
        chk("arb_ack_once", ack_cnt - a0, 1);
        chk("arb_drained", exp_q.size(), 0);

        // reset during ICW2 write pulse
        a0 = ack_cnt;
        exp_q.push_back(9'h011); exp_q.push_back(9'h117);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("icw2_pulse", int'(write), 0);
        #2 reset = 1'b1;
        #1;
        chk("async_cs_write", int'({CS, write}), 3);
        chk("async_done_busy", int'({done, busy}), 0);
        chk("async_oe", int'(dataBuffer_oe), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        chk("rst_no_ack", ack_cnt - a0, 0);
        chk("rst_idle", int'({busy, done, CS}), 1);
        exp_q.push_back(9'h011); exp_q.push_back(9'h117);
        exp_q.push_back(9'h155); exp_q.push_back(9'h18F);
        exp_q.push_back(9'h1FF);
        run_init(8'h11, 8'h17, 8'h55, 8'h8F, 8'hFF, 30);

        // alternate timing: L=7
        lowrun = 0; hirun = 0; nlow = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 100 && !done2; i++) begin
            if (!write2) lowrun++;
            else if (lowrun != 0) begin
                chk("pulse_w2", lowrun, 3);
                nlow++;
                lowrun = 0;
            end
            if (CS2 && busy2) hirun++;
            else if (hirun != 0) begin
                chk("recov_w2", hirun, 1);
                hirun = 0;
            end
            tick();
        end
        chk("pulses2", nlow, 3);
        chk("done_lat2", cyc - t0, 21);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_cmd_writer.md
# pic_cmd_writer

CPU-side bus master that drives the 8259A write port: it generates the CS/write/A0/dataBuffer cycles that the PIC's read/write logic decodes into ICW1–ICW4 and OCW1–OCW3. On `start` it runs the full initialization sequence, skipping ICW3 and ICW4 according to ICW1. Afterwards it issues single OCW writes on request through a req/ack handshake. It sits between the system controller and the PIC bus pins and never performs reads.

## Interface

- SETUP_CYC, 1, cycles with CS low and data/A0 valid before write falls (≥1)
- PULSE_CYC, 2, cycles write is held low (≥1)
- RECOV_CYC, 2, cycles with CS high between consecutive bytes (≥1)

- clk  in  1  single clock; all outputs registered on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin init sequence; sampled only in IDLE
- icw1, icw2, icw3, icw4, ocw1_init  in  8 each  init bytes; sampled once, at the `start` edge
- ocw_req  in  1  level request for one OCW write; held until `ocw_ack`
- ocw_sel  in  2  01=OCW1, 10=OCW2, 11=OCW3, 00=illegal
- ocw_data  in  8  OCW byte; sampled with `ocw_req`
- ocw_ack  out  1  one-cycle pulse, final RECOV cycle of the serviced OCW
- ocw_err  out  1  one-cycle pulse when `ocw_req` is sampled with `ocw_sel`=00 (no bus cycle)
- busy  out  1  bus sequence in progress
- done  out  1  init complete; sticky until next accepted `start` or reset
- CS  out  1  chip select, active-low
- write  out  1  write strobe, active-low
- Read  out  1  read strobe, constantly 1
- A0  out  1  address bit
- dataBuffer  out  8  write data
- dataBuffer_oe  out  1  data drive enable; high whenever CS=0

## Operation

- Reset value of all outputs: CS=1, write=1, Read=1, A0=0, dataBuffer=0, dataBuffer_oe=0, busy=0, done=0, ocw_ack=0, ocw_err=0.
- Reset mid-cycle: outputs return to reset values asynchronously. The sequence aborts, `done` clears, and no ack is issued.
- Sequence FSM states: IDLE, ICW1, ICW2, ICW3, ICW4, OCW1I, OCWX.
  - ICW1 is followed by ICW2.
  - After ICW2: go to ICW3 if icw1[1]=0 (cascade); else ICW4 if icw1[0]=1; else OCW1I.
  - After ICW3: go to ICW4 if icw1[0]=1; else OCW1I.
  - After ICW4: go to OCW1I.
  - OCW1I returns to IDLE and sets `done`.
  - OCWX returns to IDLE and pulses `ocw_ack`.
- Bus byte encoding (forced bits override input data):
  - ICW1: A0=0, D4 forced to 1.
  - ICW2, ICW3, ICW4, OCW1: A0=1, data unchanged.
  - OCW2: A0=0, D4:D3 forced to 00.
  - OCW3: A0=0, D4:D3 forced to 01.
- Bus-cycle sub-FSM per byte:
  - SETUP (SETUP_CYC cycles): CS=0, write=1, A0 and data valid.
  - PULSE (PULSE_CYC cycles): write=0.
  - HOLD (1 cycle): write=1, CS=0, data still valid.
  - RECOV (RECOV_CYC cycles): CS=1, oe=0.
  - Byte length L = SETUP_CYC+PULSE_CYC+1+RECOV_CYC (default 6).
- A0 and dataBuffer are constant from the first SETUP cycle through HOLD.
- IDLE arbitration:
  - If `start` and `ocw_req` are both high, `start` wins and `ocw_req` stays pending.
  - `ocw_req` is serviced only when done=1; otherwise it waits unacknowledged.
- `start` is ignored while busy. `ocw_req` while busy waits.

## Timing

- `start` sampled high in cycle k: busy=1 and CS=0 from cycle k+1.
- Byte n occupies cycles k+1+L(n−1) … k+L·n.
- With defaults, write is low in cycles k+2, k+3 of the first byte.
- Full sequence (5 bytes, defaults): busy through k+30; done=1 and busy=0 from k+31.
- 4-byte sequence: done at k+25. 3-byte sequence: done at k+19.
- OCW: `ocw_req` sampled in IDLE in cycle j: bus cycle occupies j+1..j+L, and `ocw_ack`=1 in cycle j+L.
- The FSM resamples `ocw_req` from cycle j+L+1. The requester deasserts `ocw_req` in the cycle after it sees ack; if `ocw_req` is still high there, a new transaction starts.
- `ocw_err` pulses in cycle j+1. No bus activity follows, and `ocw_req` must be dropped.

## Test plan

- Reset then start with icw1=0x11, icw2=0x17, icw3=0x55, icw4=0x8F, ocw1_init=0xFF, defaults:
  - Exactly 5 write pulses, with (A0,data) = (0,0x11), (1,0x17), (1,0x55), (1,0x8F), (1,0xFF).
  - done=1 at k+31.
- Single mode, no ICW4 (icw1=0x12): 3 pulses (0,0x12), (1,icw2), (1,ocw1_init); done at k+19. icw1=0x01 (D4 clear): first byte on bus is 0x11.
- After done:
  - ocw_sel=10 with data 0x3F: bus byte 0x27 at A0=0, ack at j+6.
  - ocw_sel=11 with data 0x00: bus byte 0x08 at A0=0.
  - ocw_sel=00: ocw_err pulse with CS staying 1.
- start and ocw_req high together in IDLE: init runs first; OCW is serviced immediately after done, ack only once.
- Assert reset during PULSE of ICW2: CS=1 and write=1 in the same cycle (async); done=0; no ack; a new start replays from ICW1.
- SETUP_CYC=2, PULSE_CYC=3, RECOV_CYC=1: L=7; write low exactly 3 cycles per byte; CS high exactly 1 cycle between bytes.
